// File: rtl/rx_pkg.sv
// Shared types and constants for the serial receive controller.
// Contents: FSM state enum, serial line levels, default data width.
// No logic; imported by the controller, its interface and sub-modules.
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic START_LEVEL       = 1'b0;
  localparam logic STOP_LEVEL        = 1'b1;
  localparam int   DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/serial_rx_controller_if.sv
// Received-byte output slot: byte, valid flag and consumer ready.
// master = controller (drives DataOut/DataValid), slave = consumer (drives DataReady).
// Transfer occurs on any cycle with DataValid & DataReady.
interface serial_rx_controller_if #(
  parameter int DATA_BITS = rx_pkg::DEFAULT_DATA_BITS
);

  logic [DATA_BITS-1:0] DataOut;
  logic                 DataValid;
  logic                 DataReady;

  modport master (
    output DataOut,
    output DataValid,
    input  DataReady
  );

  modport slave (
    input  DataOut,
    input  DataValid,
    output DataReady
  );

endinterface

// File: rtl/rx_shift_reg.sv
// Right-shifting deserialiser: serial_in enters at the MSB so the first bit lands in bit 0.
// Ports: clk, clear (synchronous zero), shift_en, serial_in, data (parallel out); 1-cycle latency.
// No backpressure; shifts whenever shift_en is high.
module rx_shift_reg #(
  parameter int DATA_BITS = rx_pkg::DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data
);

  generate
    if (DATA_BITS == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (clear)         data <= '0;
        else if (shift_en) data <= serial_in;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (clear)         data <= '0;
        else if (shift_en) data <= {serial_in, data[DATA_BITS-1:1]};
      end
    end
  endgenerate

endmodule

// File: rtl/serial_rx_controller.sv
// Frame controller for the serial receive path: start detect, LSB-first data shift, stop check,
// single-entry output slot. Data valid 1 cycle after the stop sample; error pulses are registered.
// A full, unaccepted slot drops the new frame and pulses Overrun. Optional parity: RX_PARITY_EN.
// Ports: clk/reset (sync, active high), SerialIn/BitValid sample strobe, Count from the bit counter,
// ClearCounter/IncCounter to it, FramingError/Overrun (+ParityError) pulses, bus = output slot.
module serial_rx_controller
  import rx_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SerialIn,
  input  logic       BitValid,
  input  logic [7:0] Count,
  output logic       ClearCounter,
  output logic       IncCounter,
  output logic       FramingError,
  output logic       Overrun,
`ifdef RX_PARITY_EN
  output logic       ParityError,
`endif
  serial_rx_controller_if.master bus
);

  // Count lags IncCounter by one cycle, so the last data bit is seen with Count == DATA_BITS-1.
  localparam logic [7:0] LAST_COUNT = 8'(DATA_BITS - 1);

  rx_state_t            state, next_state;
  logic [DATA_BITS-1:0] shift_data;
  logic [DATA_BITS-1:0] data_out_q;
  logic                 data_valid_q;
  logic                 shift_en;
  logic                 frame_done;
  logic                 stop_ok;
  logic                 slot_free;
  logic                 parity_ok;
  logic                 load;

  rx_shift_reg #(.DATA_BITS(DATA_BITS)) u_shift (
    .clk       (clk),
    .clear     (reset),
    .shift_en  (shift_en),
    .serial_in (SerialIn),
    .data      (shift_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    ClearCounter = 1'b0;
    IncCounter   = 1'b0;
    shift_en     = 1'b0;
    case (state)
      IDLE: begin
        ClearCounter = 1'b1;
        if (BitValid && SerialIn == START_LEVEL) next_state = DATA;
      end
      DATA: begin
        if (BitValid) begin
          IncCounter = 1'b1;
          shift_en   = 1'b1;
`ifdef RX_PARITY_EN
          if (Count == LAST_COUNT) next_state = PARITY;
`else
          if (Count == LAST_COUNT) next_state = STOP;
`endif
        end
      end
      PARITY: begin
`ifdef RX_PARITY_EN
        if (BitValid) next_state = STOP;
`else
        next_state = IDLE;
`endif
      end
      STOP: begin
        if (BitValid) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef RX_PARITY_EN
  // Even parity: data bits plus the parity bit must XOR to zero.
  always_ff @(posedge clk) begin
    if (reset)                           parity_ok <= 1'b1;
    else if (state == PARITY && BitValid) parity_ok <= ~^{shift_data, SerialIn};
  end
`else
  assign parity_ok = 1'b1;
`endif

  assign frame_done = (state == STOP) && BitValid;
  assign stop_ok    = (SerialIn == STOP_LEVEL);
  // A handshake in the completing cycle frees the slot for the new byte.
  assign slot_free  = !data_valid_q || bus.DataReady;
  assign load       = frame_done && stop_ok && parity_ok && slot_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      FramingError <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      FramingError <= frame_done && !stop_ok;
      Overrun      <= frame_done && stop_ok && parity_ok && !slot_free;
      if (load) begin
        data_out_q   <= shift_data;
        data_valid_q <= 1'b1;
      end else if (data_valid_q && bus.DataReady) begin
        data_valid_q <= 1'b0;
      end
    end
  end

`ifdef RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) ParityError <= 1'b0;
    else       ParityError <= frame_done && stop_ok && !parity_ok;
  end
`endif

  assign bus.DataOut   = data_out_q;
  assign bus.DataValid = data_valid_q;

endmodule
